// File: rtl/envelope_gen_if.sv
// envelope_gen_if: oscillator sample in, scaled sample and
// envelope status out, grouped as one bundle.
interface envelope_gen_if;
   logic       gate;
   logic [7:0] sample_in;
   logic [7:0] sample_out;
   logic [7:0] env_level;
   logic [2:0] env_state;
   logic       busy;

   modport master (
      output gate, sample_in,
      input  sample_out, env_level, env_state, busy
   );

   modport slave (
      input  gate, sample_in,
      output sample_out, env_level, env_state, busy
   );
endinterface

// File: rtl/envelope_gen.sv
// envelope_gen: ADSR amplitude envelope on a prescaled tick,
// scaling the oscillator sample by the current level.
module envelope_gen #(
   parameter int TICK_COUNTS   = 1000,
   parameter int ATTACK_STEP   = 8,
   parameter int DECAY_STEP    = 2,
   parameter int SUSTAIN_LEVEL = 160,
   parameter int RELEASE_STEP  = 4
) (
   input  logic           clk,
   input  logic           rst,
   envelope_gen_if.slave  bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ATTACK  = 3'd1;
   localparam logic [2:0] S_DECAY   = 3'd2;
   localparam logic [2:0] S_SUSTAIN = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam int PW =
      (TICK_COUNTS > 1) ? $clog2(TICK_COUNTS) : 1;

   logic [PW-1:0] r_presc;
   logic          w_tick;
   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [7:0]    r_level;
   logic [7:0]    w_level_nxt;
   logic [7:0]    r_out;
   logic          r_busy;
   logic [8:0]    w_add;
   logic [8:0]    w_dec;
   logic [8:0]    w_rel;
   logic [15:0]   w_prod;

   assign w_tick = (r_presc == PW'(TICK_COUNTS - 1));

   // 9-bit intermediates: bit 8 flags overflow or borrow
   assign w_add  = {1'b0, r_level} + 9'(ATTACK_STEP);
   assign w_dec  = {1'b0, r_level} - 9'(DECAY_STEP);
   assign w_rel  = {1'b0, r_level} - 9'(RELEASE_STEP);
   assign w_prod = {8'd0, bus.sample_in} * {8'd0, r_level};

   // free-running tick prescaler, independent of gate
   always_ff @(posedge clk) begin
      if (rst || w_tick) r_presc <= '0;
      else               r_presc <= r_presc + 1'b1;
   end

   // phase sequencing; gate edges win over tick updates
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      case (r_state)
         S_IDLE: begin
            w_level_nxt = 8'd0;
            if (bus.gate) w_state_nxt = S_ATTACK;
         end
         S_ATTACK: begin
            if (!bus.gate) begin
               w_state_nxt = S_RELEASE;
            end else if (w_tick) begin
               if (w_add >= 9'd255) begin
                  w_level_nxt = 8'd255;
                  w_state_nxt = S_DECAY;
               end else begin
                  w_level_nxt = w_add[7:0];
               end
            end
         end
         S_DECAY: begin
            if (!bus.gate) begin
               w_state_nxt = S_RELEASE;
            end else if (w_tick) begin
               if (w_dec[8] ||
                   w_dec[7:0] <= 8'(SUSTAIN_LEVEL)) begin
                  w_level_nxt = 8'(SUSTAIN_LEVEL);
                  w_state_nxt = S_SUSTAIN;
               end else begin
                  w_level_nxt = w_dec[7:0];
               end
            end
         end
         S_SUSTAIN: begin
            if (!bus.gate) w_state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (bus.gate) begin
               w_state_nxt = S_ATTACK;
            end else if (w_tick) begin
               if (w_rel[8] || w_rel[7:0] == 8'd0) begin
                  w_level_nxt = 8'd0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_level_nxt = w_rel[7:0];
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_level_nxt = 8'd0;
         end
      endcase
   end

   // envelope registers; reset aborts with no release tail
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_level <= 8'd0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // scale by the pre-update level; 255 is full scale
   always_ff @(posedge clk) begin
      if (rst) r_out <= 8'd0;
      else     r_out <= w_prod[15:8];
   end

   assign bus.sample_out = r_out;
   assign bus.env_level  = r_level;
   assign bus.env_state  = r_state;
   assign bus.busy       = r_busy;
endmodule

// File: doc/envelope_gen.md
# envelope_gen

ADSR amplitude envelope stage that sits directly downstream of the oscillator. It takes the oscillator's unsigned 8-bit sawtooth sample and a note gate. It generates an 8-bit envelope level through Attack/Decay/Sustain/Release phases and outputs the sample scaled by that level. The envelope advances on a prescaled tick, so phase durations are set by parameters, not by the sample rate.

## Interface
Parameters:
- TICK_COUNTS, 1000: clocks per envelope tick (≥1).
- ATTACK_STEP, 8: level increment per tick in ATTACK (1..255).
- DECAY_STEP, 2: level decrement per tick in DECAY (1..255).
- SUSTAIN_LEVEL, 160: level held in SUSTAIN (0..255).
- RELEASE_STEP, 4: level decrement per tick in RELEASE (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- gate  in  1  note held (1) / released (0), sampled every clock.
- sample_in  in  8  unsigned oscillator sample.
- sample_out  out  8  registered scaled sample.
- env_level  out  8  current envelope level.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  high when env_state != IDLE.

## Operation
- Prescaler: 0..TICK_COUNTS-1 free-running counter. tick=1 in the cycle it equals TICK_COUNTS-1, then it wraps to 0. It is not restarted by gate.
- Level arithmetic: 9-bit intermediates, saturating. Additions clamp at 255. Subtractions clamp at the phase floor, which is SUSTAIN_LEVEL in DECAY and 0 in RELEASE.
- State transitions are evaluated every clock. Gate-driven transitions take priority over tick updates: in a cycle where a gate transition fires, the level is unchanged.
- IDLE: level 0.
  - gate=1 → ATTACK on the next clock. The level starts from 0.
- ATTACK:
  - gate=0 → RELEASE.
  - Otherwise, on tick: level = min(level+ATTACK_STEP, 255). If the result is 255, go to DECAY in the same update.
- DECAY:
  - gate=0 → RELEASE.
  - Otherwise, on tick: level = max(level−DECAY_STEP, SUSTAIN_LEVEL). If the result equals SUSTAIN_LEVEL, go to SUSTAIN.
  - If SUSTAIN_LEVEL=255, the first DECAY tick moves to SUSTAIN with level 255.
- SUSTAIN: level held.
  - gate=0 → RELEASE.
- RELEASE:
  - gate=1 → ATTACK (retrigger), starting from the current level, not from 0.
  - Otherwise, on tick: level = max(level−RELEASE_STEP, 0). If the result is 0, go to IDLE.
- Scaling: sample_out = (sample_in × env_level) >> 8, computed with a 16-bit product.
  - Full scale is 255, not 256, so 255×255 gives 254.
  - env_level=0 gives 0.

## Timing
- Reset: while rst=1 at a clock edge, the following hold from the next edge:
  - env_state=IDLE, env_level=0, sample_out=0, busy=0, prescaler=0.
  - Reset mid-phase aborts immediately, with no release tail.
- Gate response: the state changes 1 clock after gate is sampled.
- Level response: the level changes only on tick cycles, except that gate transitions never change the level.
- sample_out latency: 1 clock. It uses the env_level and sample_in values registered at that same edge's inputs, i.e. the pre-update env_level.
- busy and env_level are registered outputs taken directly from state.
- Simultaneous gate fall and tick in ATTACK: go to RELEASE with the level unchanged.
- Simultaneous gate rise and tick in RELEASE: go to ATTACK with the level unchanged.
- gate toggling faster than a tick is legal. Each edge causes its own state change.

## Test plan
Run with TICK_COUNTS=4 and all other parameters at their defaults.

1. Reset: assert rst for 2 clocks with gate=1 and sample_in=200 → sample_out=0, env_level=0, env_state=0, busy=0. After rst deasserts, ATTACK is entered 1 clock later.
2. Full ADSR:
   - Hold gate=1 → ATTACK takes 32 ticks, levels 8, 16 … 248, then clamp to 255 → DECAY.
   - DECAY takes 48 ticks: 253 … 161, then clamp to 160 → SUSTAIN, and the level holds there.
   - Drop gate → RELEASE takes 40 ticks down to 0 → IDLE, busy=0.
3. Scaling:
   - In SUSTAIN (level 160) with sample_in=200 → sample_out=125 one clock later.
   - At env=255 with sample_in=255 → 254.
   - With sample_in=0 → 0.
4. Early release: drop gate when the level is 40 in ATTACK → RELEASE with level 40. The level then decrements by 4 per tick and reaches IDLE after 10 ticks.
5. Retrigger: raise gate while in RELEASE at level 100 → ATTACK continuing from 100 (108, 116, …). There is no drop to 0.
6. Collision and reset:
   - Gate fall coincident with a tick in ATTACK → RELEASE with the level unchanged that cycle.
   - Assert rst in DECAY → all outputs 0 and IDLE on the next clock.
